// File: rtl/kr580_pkg.sv
// Shared definitions for KR580 port-mapped peripherals: port offsets within a
// peripheral's window and the timer's ctrl/status bit positions.
package kr580_pkg;

  typedef enum logic [2:0] {
    OFS_RELOAD_LO = 3'd0,
    OFS_RELOAD_HI = 3'd1,
    OFS_CTRL      = 3'd2,
    OFS_STATUS    = 3'd3,
    OFS_LATCH_LO  = 3'd4,
    OFS_LATCH_HI  = 3'd5
  } port_ofs_e;

  localparam logic [7:0] NUM_PORTS = 8'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STAT_PEND = 0;

endpackage

// File: rtl/kr580_prescaler.sv
// Clock prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the
// cycle it wraps back to 0; held at 0 while disabled or cleared.
module kr580_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            W    = $clog2(PRESCALE);
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  // A clear on the wrap cycle suppresses the tick: the clearing write wins.
  assign tick = en & ~clr & (r_cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr || !en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/kr580_port_timer.sv
// KR580 port-mapped interval timer and interrupt source (6-port window at BASE).
// Defining KR580_TIMER_LATCH_EN adds a count snapshot latch readable at +4/+5.
module kr580_port_timer
  import kr580_pkg::*;
#(
  parameter logic [7:0] BASE     = 8'h40,
  parameter int         PRESCALE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] pa,
  input  logic [7:0] po,
  input  logic       pw,
  output logic [7:0] pi,
  output logic       intr
);

  logic [7:0]  w_ofs;
  logic        w_hit;
  port_ofs_e   w_sel;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_tick;
  logic        w_expire;

  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [2:0]  r_ctrl;
  logic        r_pend;
  logic        r_intr;

  // Offset arithmetic wraps mod 256, so a window straddling 8'hFF decodes naturally.
  assign w_ofs     = pa - BASE;
  assign w_hit     = (w_ofs < NUM_PORTS);
  assign w_sel     = port_ofs_e'(w_ofs[2:0]);

  assign w_wr_lo   = pw & w_hit & (w_sel == OFS_RELOAD_LO);
  assign w_wr_hi   = pw & w_hit & (w_sel == OFS_RELOAD_HI);
  assign w_wr_ctrl = pw & w_hit & (w_sel == OFS_CTRL);
  assign w_wr_stat = pw & w_hit & (w_sel == OFS_STATUS);

  kr580_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (r_ctrl[CTRL_EN]),
    .clr     (w_wr_hi),
    .tick    (w_tick)
  );

  assign w_expire = w_tick & (r_count == 16'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= '0;
      r_count  <= '0;
      r_ctrl   <= '0;
      r_pend   <= 1'b0;
      r_intr   <= 1'b0;
    end else begin
      if (w_wr_lo) r_reload[7:0]  <= po;
      if (w_wr_hi) r_reload[15:8] <= po;

      if (w_wr_hi)       r_count <= {po, r_reload[7:0]};
      else if (w_expire) r_count <= r_reload;
      else if (w_tick)   r_count <= r_count - 16'd1;

      // A CPU ctrl write overrides the one-shot self-disable on the same edge.
      if (w_wr_ctrl)                              r_ctrl <= po[2:0];
      else if (w_expire && !r_ctrl[CTRL_AUTO])    r_ctrl[CTRL_EN] <= 1'b0;

      if (w_expire)                          r_pend <= 1'b1;
      else if (w_wr_stat && po[STAT_PEND])   r_pend <= 1'b0;

      r_intr <= r_pend & r_ctrl[CTRL_IE];
    end
  end

  assign intr = r_intr;

`ifdef KR580_TIMER_LATCH_EN
  logic [15:0] r_latch;
  logic        w_wr_latch;

  assign w_wr_latch = pw & w_hit & (w_sel == OFS_LATCH_LO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_latch <= '0;
    end else if (w_wr_latch) begin
      r_latch <= r_count;
    end
  end
`endif

  always_comb begin
    pi = 8'h00;
    if (w_hit) begin
      case (w_sel)
        OFS_RELOAD_LO: pi = r_reload[7:0];
        OFS_RELOAD_HI: pi = r_reload[15:8];
        OFS_CTRL:      pi = {5'b0, r_ctrl};
        OFS_STATUS:    pi = {7'b0, r_pend};
`ifdef KR580_TIMER_LATCH_EN
        OFS_LATCH_LO:  pi = r_latch[7:0];
        OFS_LATCH_HI:  pi = r_latch[15:8];
`endif
        default:       pi = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_kr580_port_timer.sv
// Directed bench for kr580_port_timer (BASE=8'hFE, PRESCALE=4); expected
// values are hand-computed cycle counts and register contents.
module tb_kr580_port_timer;

  localparam logic [7:0] P_LO   = 8'hFE;
  localparam logic [7:0] P_HI   = 8'hFF;
  localparam logic [7:0] P_CTRL = 8'h00;
  localparam logic [7:0] P_STAT = 8'h01;
  localparam logic [7:0] P_LLO  = 8'h02;
  localparam logic [7:0] P_LHI  = 8'h03;

`ifdef KR580_TIMER_LATCH_EN
  localparam int LATCH_ON = 1;
`else
  localparam int LATCH_ON = 0;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pa      = 8'h00;
  logic [7:0] po      = 8'h00;
  logic       pw      = 1'b0;
  logic [7:0] pi;
  logic       intr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  kr580_port_timer #(
    .BASE     (8'hFE),
    .PRESCALE (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .pa      (pa),
    .po      (po),
    .pw      (pw),
    .pi      (pi),
    .intr    (intr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pa = a;
    po = d;
    pw = 1'b1;
    @(negedge clock);
    pw = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    pa = a;
    #1;
    d = pi;
  endtask

  task automatic wait_pend(output int t);
    t = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      pa = P_STAT;
      #1;
      if (pi[0]) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] d;
    int t0, t1, t2;

    // Reset state
    pa = 8'h42;
    #1;
    chk("rst_intr", int'(intr), 0);
    chk("rst_pi_42", int'(pi), 'h00);
    rd(P_LO, d);   chk("rst_reload_lo", int'(d), 'h00);
    rd(P_CTRL, d); chk("rst_ctrl", int'(d), 'h00);
    rd(P_STAT, d); chk("rst_stat", int'(d), 'h00);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    rd(P_STAT, d); chk("idle_no_expiry", int'(d), 'h00);
    chk("idle_intr", int'(intr), 0);

    // Auto-reload: reload=3, PRESCALE=4 -> period 16
    wr(P_LO, 8'h03);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h07);
    t0 = cyc;
    wait_pend(t1);
    chk("auto_first", t1 - t0, 16);
    chk("auto_intr_lag0", int'(intr), 0);
    @(negedge clock);
    chk("auto_intr_lag1", int'(intr), 1);
    wr(P_STAT, 8'h01);
    chk("auto_intr_hold", int'(intr), 1);
    @(negedge clock);
    chk("auto_intr_drop", int'(intr), 0);
    rd(P_STAT, d); chk("auto_cleared", int'(d), 'h00);
    wait_pend(t2);
    chk("auto_period", t2 - t1, 16);
    wr(P_LLO, 8'h00);
    rd(P_LLO, d); chk("auto_reloaded_cnt", int'(d), LATCH_ON ? 'h03 : 'h00);
    rd(P_CTRL, d); chk("auto_ctrl", int'(d), 'h07);
    wr(P_CTRL, 8'h00);
    wr(P_STAT, 8'h01);

    // One-shot: reload=2 -> single expiry after 12 clocks
    wr(P_LO, 8'h02);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h05);
    t0 = cyc;
    wait_pend(t1);
    chk("oneshot_time", t1 - t0, 12);
    rd(P_CTRL, d); chk("oneshot_ctrl", int'(d), 'h04);
    @(negedge clock);
    chk("oneshot_intr", int'(intr), 1);
    wr(P_STAT, 8'h01);
    repeat (40) @(negedge clock);
    rd(P_STAT, d); chk("oneshot_no_more", int'(d), 'h00);
    chk("oneshot_intr_off", int'(intr), 0);

    // Clear on the exact expiry edge: set wins
    wr(P_LO, 8'h03);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h07);
    repeat (14) @(negedge clock);
    wr(P_STAT, 8'h01);
    rd(P_STAT, d); chk("race_set_wins", int'(d), 'h01);
    repeat (4) @(negedge clock);
    wr(P_STAT, 8'h01);
    chk("race_intr_hold", int'(intr), 1);
    @(negedge clock);
    chk("race_intr_drop", int'(intr), 0);
    wr(P_CTRL, 8'h00);
    wr(P_STAT, 8'h01);

    // ctrl write on a one-shot expiry edge: written value wins
    wr(P_LO, 8'h00);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h01);
    repeat (2) @(negedge clock);
    wr(P_CTRL, 8'h03);
    rd(P_CTRL, d); chk("ctrl_race", int'(d), 'h03);
    rd(P_STAT, d); chk("ctrl_race_pend", int'(d), 'h01);
    wr(P_CTRL, 8'h00);
    wr(P_STAT, 8'h01);

    // +1 write on a tick edge: load and prescaler clear win, IE off
    wr(P_LO, 8'h05);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h03);
    t0 = cyc;
    repeat (2) @(negedge clock);
    wr(P_HI, 8'h00);
    wait_pend(t1);
    chk("hi_race_time", t1 - t0, 28);
    @(negedge clock);
    chk("ie_off_intr", int'(intr), 0);
    wr(P_CTRL, 8'h00);
    wr(P_STAT, 8'h01);

    // Address decode across the 8'hFF wrap
    wr(8'h00, 8'h04);
    rd(P_CTRL, d); chk("dec_ctrl_00", int'(d), 'h04);
    wr(8'h10, 8'hFF);
    wr(8'h04, 8'hFF);
    rd(P_CTRL, d); chk("dec_ignored", int'(d), 'h04);
    rd(8'h10, d);  chk("dec_read_10", int'(d), 'h00);
    rd(8'h04, d);  chk("dec_read_04", int'(d), 'h00);
    rd(P_LO, d);   chk("dec_reload_lo", int'(d), 'h05);
    wr(8'h00, 8'h00);

    // Counter snapshot latch
    wr(P_LO, 8'h34);
    wr(P_HI, 8'h12);
    wr(P_LLO, 8'h00);
    rd(P_LLO, d); chk("latch_lo", int'(d), LATCH_ON ? 'h34 : 'h00);
    rd(P_LHI, d); chk("latch_hi", int'(d), LATCH_ON ? 'h12 : 'h00);
    wr(P_LHI, 8'h99);
    rd(P_LHI, d); chk("latch_hi_ro", int'(d), LATCH_ON ? 'h12 : 'h00);

    // Asynchronous reset mid-operation
    wr(P_LO, 8'h00);
    wr(P_HI, 8'h00);
    wr(P_CTRL, 8'h05);
    repeat (6) @(negedge clock);
    chk("pre_arst_intr", int'(intr), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_intr", int'(intr), 0);
    rd(P_CTRL, d); chk("arst_ctrl", int'(d), 'h00);
    rd(P_STAT, d); chk("arst_stat", int'(d), 'h00);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
